// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register-file target.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the core_clk domain and flags edges plus START/STOP.
`timescale 1ns/1ps
module i2c_bus_sync (
    input  logic core_clk,
    input  logic core_rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_meta;
    logic scl_s;
    logic scl_prev;
    logic sda_meta;
    logic sda_prev;

    // Idle bus is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_s    <= scl_meta;
            scl_prev <= scl_s;
            sda_meta <= sda_i;
            sda_s    <= sda_meta;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// EEPROM-style I2C target: pointer byte after the address, then auto-incrementing
// register writes or reads. Oversamples the bus on core_clk, never stretches scl.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    localparam int        PTR_W       = $clog2(DEPTH)
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    import i2c_pkg::*;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_tgt_state_t state;
    i2c_tgt_state_t state_next;

    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             ack_phase;
    logic             rw;
    logic [PTR_W-1:0] pointer;
    logic [7:0]       regs [DEPTH];

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       addr_match;

    i2c_bus_sync u_sync (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign rx_byte    = {shift[6:0], sda_s};
    assign byte_done  = scl_rise && (bit_cnt == 3'd7);
    assign addr_match = (rx_byte[7:1] == TARGET_ADDR) && (TARGET_ADDR != 7'h00);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ACK states span two scl_falls: the first starts driving, the second ends it.
    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR:      if (byte_done) state_next = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && ack_phase) state_next = (rw == I2C_RW_READ) ? RDATA : PTR;
                PTR:       if (byte_done) state_next = PTR_ACK;
                PTR_ACK:   if (scl_fall && ack_phase) state_next = WDATA;
                WDATA:     if (byte_done) state_next = WDATA_ACK;
                WDATA_ACK: if (scl_fall && ack_phase) state_next = WDATA;
                RDATA:     if (scl_fall && (bit_cnt == 3'd7)) state_next = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && (sda_s == I2C_NACK)) begin
                        state_next = IGNORE;
                    end else if (scl_fall && ack_phase) begin
                        state_next = RDATA;
                    end
                end
                default:   state_next = state;
            endcase
        end
    end

    // Datapath mirrors the FSM decisions; START beats a coincident scl_rise.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
            rw        <= 1'b0;
            pointer   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_valid <= 1'b0;
            if (stop_det) begin
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw   <= rx_byte[0];
                                busy <= addr_match;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                pointer <= rx_byte[PTR_W-1:0];
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                regs[pointer] <= rx_byte;
                                wr_valid      <= 1'b1;
                                wr_addr       <= pointer;
                                wr_data       <= rx_byte;
                                pointer       <= pointer + PTR_W'(1);
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= ~I2C_ACK;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                if ((state == ADDR_ACK) && (rw == I2C_RW_READ)) begin
                                    shift  <= regs[pointer];
                                    sda_oe <= ~regs[pointer][7];
                                end else begin
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                pointer <= pointer + PTR_W'(1);
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise && (sda_s == I2C_ACK)) begin
                            ack_phase <= 1'b1;
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= 3'd0;
                            shift     <= regs[pointer];
                            sda_oe    <= ~regs[pointer][7];
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (slave) that answers the APB-to-I2C master on the shared scl/sda bus.
- Holds a small byte-wide register file with an auto-incrementing pointer, EEPROM-style.
- Replaces the behavioural slave model in system-level regressions, and later ships as a configurable on-chip peripheral.
- Oversamples scl/sda on core_clk; performs no clock stretching.

Parameters:
- TARGET_ADDR, 7'h50: 7-bit I2C address this target responds to.
- DEPTH, 16: number of 8-bit registers; power of 2, 2..256.
- PTR_W, $clog2(DEPTH): pointer width (derived localparam).

Ports:
- core_clk  in  1  sole clock; must be at least 8x the scl frequency.
- core_rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  bus clock input from the pad.
- sda_i  in  1  bus data input from the pad.
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- wr_valid  out  1  one-cycle pulse when a register byte is written.
- wr_addr  out  PTR_W  register index written; valid with wr_valid.
- wr_data  out  8  byte written; valid with wr_valid.
- busy  out  1  high from an addressed START to STOP or address mismatch.

Behaviour:
- Reset: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, pointer=0, all registers=8'h00, synchronizers=1.
- Input conditioning: 2-flop synchronizer on scl_i and sda_i, then a previous-sample register.
  - scl_rise/scl_fall: single-cycle strobes from the synced scl.
  - START: synced sda falls while synced scl=1.
  - STOP: synced sda rises while synced scl=1.
- Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register with a 3-bit bit counter.
- sda_oe changes only on the cycle after scl_fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: START -> ADDR.
- ADDR: after 8 bits:
  - Bits[7:1]==TARGET_ADDR -> ADDR_ACK, busy=1.
  - Otherwise -> IGNORE, sda_oe stays 0.
- ADDR_ACK: drive sda_oe=1 for one scl period (from the scl_fall ending bit 8 to the next scl_fall). Then:
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA; the first data bit is driven immediately after the ACK is released.
- PTR: 8 bits received; pointer <= byte[PTR_W-1:0] (upper bits ignored) -> PTR_ACK (ACK) -> WDATA.
- WDATA: 8 bits received -> WDATA_ACK, which drives the ACK.
  - Register write, wr_valid pulse, wr_addr=pointer, wr_data=byte, all on the cycle of the 8th scl_rise+1.
  - Pointer increments, wrapping DEPTH-1 -> 0.
  - Back to WDATA.
- RDATA: shift out reg[pointer] MSB first.
  - sda_oe = ~bit, updated after each scl_fall.
  - After 8 bits release SDA and increment the pointer (with wrap) -> RDATA_ACK.
- RDATA_ACK: sample the master's bit on scl_rise.
  - 0 (ACK) -> RDATA with the next byte.
  - 1 (NACK) -> IGNORE with SDA released.
- IGNORE: no bus drive; waits for START or STOP.
- STOP in any state -> IDLE; sda_oe=0, busy=0. Pointer and registers are retained.
- START in any non-IDLE state (repeated start, including mid-byte) -> ADDR; bit counter cleared, sda_oe=0. Pointer retained, so write-pointer then Sr+read works.
- START and scl_rise in the same cycle: START wins and no bit is sampled.
- core_rst asserted mid-transfer: everything returns to reset values immediately and SDA is released. The target re-engages only at the next START.
- General-call address 7'h00 is not supported: it is treated as a mismatch.

Decomposition:
- Package i2c_pkg holds:
  - State enum type i2c_tgt_state_t.
  - Constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_READ=1'b1.
- Sub-module i2c_bus_sync: synchronizer plus edge/START/STOP detector. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- Top holds the FSM, shift register, pointer and register array.

Test Plan:
- Write: S, 0xA0, 0x03, 0x5A, 0xC3, P -> ACK on all four bytes; wr_valid pulses at wr_addr=3 (data 0x5A) then wr_addr=4 (data 0xC3); busy low after P.
- Random read: after the above, S, 0xA0, 0x03, Sr, 0xA1, read 2 bytes with ACK then NACK, P -> master reads 0x5A, 0xC3; SDA released after the NACK.
- Wrap: write pointer 0x0F, data 0x11, 0x22 -> writes reg15=0x11 and reg0=0x22; read-back from pointer 0x0F returns 0x11 then 0x22.
- Wrong address: S, 0xA2, ... P -> sda_oe never asserts, no wr_valid, busy stays 0; the master sees a NACK.
- Abort: START, then a STOP after 4 bits of the data byte -> no write, state IDLE, sda_oe=0; a subsequent full write succeeds.
- Reset mid-read: core_rst pulsed while the target drives a 0 data bit -> sda_oe=0 within the reset cycle; registers read back 0x00 after the next transaction.
